// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, word
// geometry and the default load base address.
package imem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 2;

  localparam logic [63:0] BASE_ADDR_DEFAULT = 64'd0;

endpackage

// File: rtl/Cla64bit.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups chained through
// group generate/propagate terms.
module Cla64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum
);

  logic [63:0] g;
  logic [63:0] p;
  logic [63:0] c;

  always_comb begin
    logic carry;
    logic grp_g;
    logic grp_p;
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    carry = cin;
    for (int k = 0; k < 16; k++) begin
      c[4*k]   = carry;
      c[4*k+1] = g[4*k] | (p[4*k] & carry);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
      grp_g = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p = &p[4*k +: 4];
      carry = grp_g | (grp_p & carry);
    end
    sum = p ^ c;
  end

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// little-endian, holding the core off fetch while a session is in progress.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | no session; waits for start
//   S_ACCEPT | word_ready high; waits for a word
//   S_WRITE  | emits the latched word one byte per cycle, lanes 0..3
//   S_FIN    | one-cycle done pulse, then back to S_IDLE
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [63:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [7:0]  wr_byte,
  output logic        busy,
  output logic        done,
  output logic        overflow_err,
  output logic [8:0]  words_written
);

  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(MEM_BYTES);

  state_t            state_q;
  state_t            state_d;
  logic [63:0]       ptr_q;
  logic [63:0]       ptr_next;
  logic [63:0]       lane_addr;
  logic [31:0]       word_q;
  logic              last_q;
  logic [LANE_W-1:0] lane_q;
  logic [8:0]        count_q;
  logic              ovf_q;
  logic              last_lane;
  logic              mem_full;

  assign last_lane = (lane_q == LANE_W'(BYTES_PER_WORD - 1));
  assign ptr_next  = ptr_q + 64'(BYTES_PER_WORD);
  assign mem_full  = (ptr_next == END_ADDR);

  Cla64bit u_addr_add (
    .a   (ptr_q),
    .b   ({{(64-LANE_W){1'b0}}, lane_q}),
    .cin (1'b0),
    .sum (lane_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    word_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        word_ready = 1'b1;
        if (word_valid) state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (last_lane) begin
          if (last_q || mem_full) state_d = S_FIN;
          else                    state_d = S_ACCEPT;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address and data are forced to zero outside write cycles.
  assign wr_addr = wr_en ? lane_addr : 64'd0;
  assign wr_byte = wr_en ? word_q[{lane_q, 3'b000} +: 8] : 8'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= BASE_ADDR;
      word_q  <= '0;
      last_q  <= 1'b0;
      lane_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ptr_q   <= BASE_ADDR;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (word_valid) begin
            word_q <= word_data;
            last_q <= word_last;
            lane_q <= '0;
          end
        end
        S_WRITE: begin
          lane_q <= lane_q + 1'b1;
          if (last_lane) begin
            ptr_q   <= ptr_next;
            count_q <= count_q + 9'd1;
            if (!last_q && mem_full) ovf_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign words_written = count_q;
  assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a transaction-level model (queue of pending byte
// writes per accepted word) checked every cycle, plus literal spot checks.
module tb_imem_loader;

  localparam int unsigned MEM_BYTES = 1024;
  localparam logic [63:0] BASE      = 64'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_last = 1'b0;
  logic        word_ready;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [7:0]  wr_byte;
  logic        busy;
  logic        done;
  logic        overflow_err;
  logic [8:0]  words_written;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .word_valid    (word_valid),
    .word_data     (word_data),
    .word_last     (word_last),
    .word_ready    (word_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_byte       (wr_byte),
    .busy          (busy),
    .done          (done),
    .overflow_err  (overflow_err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a session either drains its pending byte queue, finishes,
  // or waits for the next word.
  typedef struct {
    logic [63:0] a;
    logic [7:0]  b;
  } wr_t;

  wr_t         q[$];
  bit          m_sess = 1'b0;
  bit          m_fin = 1'b0;
  bit          m_last = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_cnt = 0;
  logic [63:0] m_ptr = BASE;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_sess = 1'b0;
      m_fin  = 1'b0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
      m_ptr  = BASE;
    end else if (!m_sess) begin
      if (start) begin
        m_sess = 1'b1;
        m_fin  = 1'b0;
        m_ptr  = BASE;
        m_cnt  = 0;
        m_ovf  = 1'b0;
      end
    end else if (q.size() > 0) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        m_cnt++;
        m_ptr = m_ptr + 64'd4;
        if (m_last) m_fin = 1'b1;
        else if (m_ptr == BASE + 64'(MEM_BYTES)) begin
          m_fin = 1'b1;
          m_ovf = 1'b1;
        end
      end
    end else if (m_fin) begin
      m_sess = 1'b0;
      m_fin  = 1'b0;
    end else if (word_valid) begin
      for (int i = 0; i < 4; i++) begin
        wr_t w;
        w.a = m_ptr + 64'(i);
        w.b = word_data[8*i +: 8];
        q.push_back(w);
      end
      m_last = word_last;
    end
  end

  // Observation log used by the literal checks.
  logic [7:0]  wlog [0:1023];
  int          wcount = 0;
  int          acc_n = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  bit          first_seen = 1'b0;
  logic [63:0] first_addr = '0;

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_sess));
    chk("word_ready", 64'(word_ready), 64'(m_sess && q.size() == 0 && !m_fin));
    chk("wr_en", 64'(wr_en), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("wr_addr", wr_addr, q[0].a);
      chk("wr_byte", 64'(wr_byte), 64'(q[0].b));
    end else begin
      chk("wr_addr_idle", wr_addr, 64'd0);
      chk("wr_byte_idle", 64'(wr_byte), 64'd0);
    end
    chk("done", 64'(done), 64'(m_sess && q.size() == 0 && m_fin));
    chk("words_written", 64'(words_written), 64'(m_cnt));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));

    if (wr_en) begin
      wlog[wr_addr[9:0]] = wr_byte;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_addr = wr_addr;
      end
      wcount++;
    end
    if (word_valid && word_ready) begin
      acc_cyc = cyc;
      acc_n++;
    end
    if (done) done_cyc = cyc;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wcount     = 0;
    acc_n      = 0;
    first_seen = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    word_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input int gap);
    int n = 0;
    word_valid = 1'b1;
    word_data  = d;
    word_last  = l;
    while (!word_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_timeout", 64'(n < 50), 64'd1);
    tick();
    word_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_timeout", 64'(n < budget), 64'd1);
    tick();
  endtask

  initial begin
    logic [31:0] w3 [0:2];
    int          n;

    do_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_words", 64'(words_written), 64'd0);

    // single word, last=1
    clear_log();
    pulse_start();
    send(32'h00A3A403, 1'b1, 0);
    wait_done(20);
    chk("w0_b0", 64'(wlog[0]), 64'h03);
    chk("w0_b1", 64'(wlog[1]), 64'hA4);
    chk("w0_b2", 64'(wlog[2]), 64'hA3);
    chk("w0_b3", 64'(wlog[3]), 64'h00);
    chk("w0_count", 64'(wcount), 64'd4);
    chk("done_latency", 64'(done_cyc - acc_cyc), 64'd5);
    chk("w0_words", 64'(words_written), 64'd1);

    // three words with valid gaps
    repeat (2) tick();
    clear_log();
    w3[0] = 32'h03020100;
    w3[1] = 32'h07060504;
    w3[2] = 32'h0B0A0908;
    pulse_start();
    send(w3[0], 1'b0, 2);
    send(w3[1], 1'b0, 2);
    send(w3[2], 1'b1, 0);
    wait_done(40);
    chk("w3_count", 64'(wcount), 64'd12);
    for (int i = 0; i < 12; i++) chk("w3_byte", 64'(wlog[i]), 64'(i));
    chk("w3_words", 64'(words_written), 64'd3);

    // start during WRITE and word_valid in IDLE are both ignored
    repeat (2) tick();
    pulse_start();
    word_valid = 1'b1;
    word_data  = 32'h11223344;
    word_last  = 1'b1;
    n = 0;
    while (!wr_en && n < 20) begin
      tick();
      n++;
    end
    start = 1'b1;
    tick();
    tick();
    start      = 1'b0;
    word_valid = 1'b0;
    wait_done(20);
    clear_log();
    word_valid = 1'b1;
    repeat (5) tick();
    word_valid = 1'b0;
    chk("idle_valid_writes", 64'(wcount), 64'd0);
    chk("idle_valid_busy", 64'(busy), 64'd0);

    // overflow: 257 words offered, none marked last
    repeat (2) tick();
    clear_log();
    pulse_start();
    word_valid = 1'b1;
    word_last  = 1'b0;
    word_data  = $urandom;
    n = 0;
    while (!done && n < 3000) begin
      if (word_ready) begin
        tick();
        word_data = $urandom;
      end else tick();
      n++;
    end
    chk("ovf_timeout", 64'(n < 3000), 64'd1);
    repeat (5) tick();
    word_valid = 1'b0;
    chk("ovf_writes", 64'(wcount), 64'd1024);
    chk("ovf_accepts", 64'(acc_n), 64'd256);
    chk("ovf_flag", 64'(overflow_err), 64'd1);
    chk("ovf_words", 64'(words_written), 64'd256);

    // reset in the middle of the second word
    repeat (2) tick();
    pulse_start();
    send(32'hDEADBEEF, 1'b0, 0);
    word_valid = 1'b1;
    word_data  = 32'hCAFEF00D;
    word_last  = 1'b0;
    n = 0;
    while (!(wr_en && wr_addr == 64'd5) && n < 30) begin
      tick();
      n++;
    end
    chk("mid_rst_reach", 64'(n < 30), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_words", 64'(words_written), 64'd0);
    rst_n      = 1'b1;
    word_valid = 1'b0;
    tick();
    clear_log();
    pulse_start();
    send(32'h12345678, 1'b1, 0);
    wait_done(20);
    chk("restart_addr", first_addr, 64'd0);
    chk("restart_words", 64'(words_written), 64'd1);

    // randomized sessions with stray start and idle word_valid
    for (int s = 0; s < 20; s++) begin
      int nw;
      word_valid = 1'($urandom_range(0, 1));
      word_data  = $urandom;
      repeat ($urandom_range(1, 3)) tick();
      word_valid = 1'b0;
      pulse_start();
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        start = (w == nw - 1) ? 1'b0 : 1'($urandom_range(0, 1));
        send($urandom, (w == nw - 1), $urandom_range(0, 3));
      end
      start = 1'b0;
      wait_done(40);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
